// File: rtl/digit_scan_mux_if.sv
// digit_scan_mux_if
//   Bundles the value/load handshake and the multiplexed display outputs of
//   digit_scan_mux into one interface.
//   master : drives value/load and observes the display outputs (testbench or upstream logic)
//   slave  : the scan multiplexer itself
// Signals
//   value     4*NUM_DIGITS  BCD value, nibble i = digit i
//   load      1             one-cycle strobe, capture value
//   load_ack  1             one-cycle pulse, captured value is now on the display
//   data      4             current digit nibble for the segment decoder
//   digit_en  NUM_DIGITS    one-hot active-low digit enable
//   bcd_err   1             displayed value holds a nibble above 9
`timescale 1ns/1ps
interface digit_scan_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load;
  logic                    load_ack;
  logic [3:0]              data;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    bcd_err;

  modport master (
    output value, load,
    input  load_ack, data, digit_en, bcd_err
  );

  modport slave (
    input  value, load,
    output load_ack, data, digit_en, bcd_err
  );
endinterface

// File: rtl/digit_scan_mux.sv
// digit_scan_mux
//   Holds a NUM_DIGITS-digit BCD value and time-multiplexes it onto a single
//   4-bit digit bus, one REFRESH_DIV-cycle slot per digit, with a matching
//   active-low digit enable. New values are staged and only moved into the
//   displayed (shadow) copy at a frame boundary, so a frame never tears.
// Ports
//   clk    in  system clock, rising edge
//   reset  in  asynchronous, active-high
//   bus    digit_scan_mux_if.slave: value/load in, load_ack/data/digit_en/bcd_err out
// Parameters
//   NUM_DIGITS   number of digits, digit 0 least significant
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
//   BLANK_LEAD   1 suppresses leading zeros, 0 shows every digit
`timescale 1ns/1ps
module digit_scan_mux #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LEAD  = 1
) (
  input  logic            clk,
  input  logic            reset,
  digit_scan_mux_if.slave bus
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]             r_presc;
  logic [IW-1:0]             r_idx;
  logic [4*NUM_DIGITS-1:0]   r_staging;
  logic [4*NUM_DIGITS-1:0]   r_shadow;
  logic                      r_pending;
  logic                      r_ackPend;
  logic [3:0]                r_data;
  logic [NUM_DIGITS-1:0]     r_digitEn;
  logic                      r_loadAck;
  logic                      r_bcdErr;

  logic                      w_tick;
  logic                      w_wrap;
  logic [3:0]                w_nibble;
  logic [NUM_DIGITS-1:0]     w_enable;
  logic                      w_blank;
  logic                      w_anyErr;

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  // Slot timing: the prescaler divides clk down to one tick per digit slot,
  // and the scan index steps through the digits on every tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

  // Double buffering: loads land in staging and are promoted to the shadow
  // copy only at the frame-wrap tick. A load on the wrap tick itself bypasses
  // staging so it is not delayed by a whole extra frame. The ack is held one
  // cycle so it lines up with digit 0 of the new frame on the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_staging <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_ackPend <= 1'b0;
    end else begin
      r_ackPend <= 1'b0;
      if (w_wrap && bus.load) begin
        r_shadow  <= bus.value;
        r_pending <= 1'b0;
        r_ackPend <= 1'b1;
      end else if (w_wrap && r_pending) begin
        r_shadow  <= r_staging;
        r_pending <= 1'b0;
        r_ackPend <= 1'b1;
      end else if (bus.load) begin
        r_staging <= bus.value;
        r_pending <= 1'b1;
      end
    end
  end

  // Select the current digit nibble and build the one-hot active-low enable.
  always_comb begin
    w_nibble = 4'd0;
    w_enable = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nibble    = r_shadow[4*i +: 4];
        w_enable[i] = 1'b0;
      end
    end
  end

  // A digit above 0 is blanked when it and every more significant digit are
  // zero, so digit 0 always shows even for a value of zero.
  always_comb begin
    w_blank = 1'b0;
    if ((BLANK_LEAD != 0) && (r_idx != '0)) begin
      w_blank = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if ((i >= int'(r_idx)) && (r_shadow[4*i +: 4] != 4'd0)) begin
          w_blank = 1'b0;
        end
      end
    end
  end

  // Any nibble outside 0..9 in the displayed value flags a BCD error.
  always_comb begin
    w_anyErr = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_shadow[4*i +: 4] > 4'd9) begin
        w_anyErr = 1'b1;
      end
    end
  end

  // Registered outputs, one cycle behind the index and shadow copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data    <= 4'd0;
      r_digitEn <= '1;
      r_loadAck <= 1'b0;
      r_bcdErr  <= 1'b0;
    end else begin
      r_loadAck <= r_ackPend;
      r_bcdErr  <= w_anyErr;
      if (w_blank) begin
        r_data    <= 4'd0;
        r_digitEn <= '1;
      end else begin
        r_data    <= w_nibble;
        r_digitEn <= w_enable;
      end
    end
  end

  assign bus.data     = r_data;
  assign bus.digit_en = r_digitEn;
  assign bus.load_ack = r_loadAck;
  assign bus.bcd_err  = r_bcdErr;

endmodule
